// File: rtl/plot_scheduler.sv
// Arbitrates the single plothelper engine between the cursor/disk datapath (0)
// and the board_ram redraw scan (1): grant, one-cycle enable, fixed draw hold, done.
module plot_scheduler #(
  parameter int DRAW_CYCLES = 256,
  parameter int CNT_W       = 10,
  parameter int FIXED_PRIO  = 0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       req0,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [1:0] sel0,
  input  logic       req1,
  input  logic [7:0] x1,
  input  logic [6:0] y1,
  input  logic [1:0] sel1,
  output logic [7:0] x_plot,
  output logic [6:0] y_plot,
  output logic [1:0] select,
  output logic       enable,
  output logic       busy,
  output logic       gnt,
  output logic       done0,
  output logic       done1
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAW, DONE} state_t;

  // ISSUE already spends one cycle of the draw and DRAW exits on zero.
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DRAW_CYCLES - 2);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             last_grant;
  logic             pick;

  always_comb begin
    pick = 1'b0;
    if (req0 && req1)
      pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    else if (req1)
      pick = 1'b1;
  end

  // Reset leaves last_grant at 1 so requester 0 takes the first tie.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state      <= IDLE;
      count      <= '0;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      x_plot     <= '0;
      y_plot     <= '0;
      select     <= '0;
      enable     <= 1'b0;
      busy       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
    end else begin
      enable <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt        <= pick;
            last_grant <= pick;
            x_plot     <= pick ? x1 : x0;
            y_plot     <= pick ? y1 : y0;
            select     <= pick ? sel1 : sel0;
            busy       <= 1'b1;
            enable     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          count <= LOAD;
          state <= DRAW;
        end
        DRAW: begin
          if (count == '0) begin
            done0 <= ~gnt;
            done1 <= gnt;
            state <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/plot_scheduler.md
Name: plot_scheduler

Overview:
- Shares the single plothelper drawing engine between two requesters: requester 0 is the cursor/disk datapath and requester 1 is the board_ram redraw scan.
- Each requester posts one cell-draw command (x, y, select). The scheduler arbitrates, latches the winner's command and issues a one-cycle enable to plothelper.
- It then holds off other requesters for the fixed draw time and returns a done pulse to the winner.
- Replaces the static enable_select mux in the top level.

Parameters:
DRAW_CYCLES, 256, cycles plothelper needs per cell command counted from the enable pulse; legal range 2..1023
CNT_W, 10, width of the draw counter; must hold DRAW_CYCLES-1
FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties

Ports:
clock  input  1  system clock (CLOCK_50)
resetn  input  1  asynchronous reset, active-high (name kept per codebase, polarity high)
req0  input  1  requester 0 command valid; held until done0
x0  input  8  requester 0 pixel x origin
y0  input  7  requester 0 pixel y origin
sel0  input  2  requester 0 colour/shape select
req1  input  1  requester 1 command valid; held until done1
x1  input  8  requester 1 pixel x origin
y1  input  7  requester 1 pixel y origin
sel1  input  2  requester 1 colour/shape select
x_plot  output  8  latched x to plothelper x_in
y_plot  output  7  latched y to plothelper y_in
select  output  2  latched select to plothelper select
enable  output  1  one-cycle start pulse to plothelper
busy  output  1  high from grant through done cycle
gnt  output  1  id of current or last granted requester
done0  output  1  one-cycle completion pulse to requester 0
done1  output  1  one-cycle completion pulse to requester 1

Behaviour:
- States: IDLE, ISSUE, DRAW, DONE.
- Reset, asynchronous, any state:
  - state = IDLE; counter = 0; all outputs = 0.
  - gnt = 0, last-grant register = 1, so requester 0 wins the first round-robin tie.
- IDLE:
  - No req: stay in IDLE; busy = 0.
  - Any req high at a clock edge: choose winner, latch its x/y/sel into x_plot/y_plot/select, set gnt = winner, busy = 1, go to ISSUE.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high, FIXED_PRIO=1: requester 0 wins.
  - Both high, FIXED_PRIO=0: winner = ~last_grant. last_grant updates to the winner at grant.
- ISSUE:
  - enable = 1 for exactly this cycle; counter loads DRAW_CYCLES-2; go to DRAW.
- DRAW:
  - enable = 0; counter decrements each cycle; at counter == 0 go to DONE.
  - Enable rise to DONE entry = DRAW_CYCLES cycles.
- DONE:
  - done[gnt] = 1 for one cycle; busy = 1; go to IDLE.
  - busy falls on the following cycle.
- Latency:
  - req rising edge seen at edge N: enable high in cycle N+1, done pulse in cycle N+1+DRAW_CYCLES.
  - Next grant evaluated at the first IDLE edge after DONE, so minimum command spacing is DRAW_CYCLES+2 cycles.
- Latched outputs:
  - x_plot/y_plot/select change only at grant and stay stable until the next grant; requester inputs may change after grant without effect.
  - Unlatched registers retain their last values in IDLE.
- Requester rules:
  - A requester keeps req high until its done.
  - It must drop req in the cycle after done, or a new command of the same data is assumed and granted again (re-issue is legal, not an error).
- Req dropped mid-draw: draw still completes and done is still pulsed; no abort.
- Req raised by the losing requester during DRAW: held off and granted at the next IDLE edge (it wins under round-robin).
- Only one done asserted in any cycle; done0 and done1 never overlap with enable.
- Reset asserted mid-DRAW: draw abandoned, no done pulse, counter cleared; plothelper is reset by the same signal.

Test Plan:
1. Reset, then req0=1, x0=8'd20, y0=7'd34, sel0=2'b01 with DRAW_CYCLES=4 -> enable high 1 cycle after grant with x_plot=20/y_plot=34/select=1, gnt=0, done0 4 cycles after enable, busy low 1 cycle after done0.
2. req0 and req1 high together from reset, FIXED_PRIO=0, both re-requesting after done -> grant order 0,1,0,1; done alternates; enable pulses spaced exactly DRAW_CYCLES+2 cycles.
3. Same as 2 with FIXED_PRIO=1 and req0 held continuously -> requester 1 never granted; every done is done0.
4. Grant requester 1 (x1=8'd100), then change x1 to 8'd5 during DRAW -> x_plot stays 100 through done1.
5. req0 deasserted 2 cycles after enable -> done0 still pulses at the normal cycle; scheduler returns to IDLE with busy=0.
6. Assert resetn while counter mid-DRAW -> all outputs 0 immediately (asynchronous), no done pulse; after release with req1 and req0 both high, requester 0 is granted first.
